// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller
// Time-multiplexed scan driver for a 4-digit FND display. Walks a digit
// index 0..3 at a rate of one digit slot per CLK_DIV clocks and presents
// the selected BCD nibble, the digit select and a digit-off control. New
// display values are staged in a pending register and only become active
// at a frame boundary, so a frame never mixes old and new digits.
module fnd_scan_controller #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_Load,
  input  logic [15:0] i_Value,
  input  logic        i_LZ_Suppress,
  input  logic        i_Blank,
  output logic        o_Ack,
  output logic [1:0]  o_DigitSelect,
  output logic        o_DigitOff,
  output logic [3:0]  o_BCD,
  output logic        o_FrameTick
);

  // Prescaler only needs to reach CLK_DIV-1; keep at least one bit.
  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST_COUNT = PW'(CLK_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [1:0]    digit_idx;
  logic [15:0]   active_value;
  logic [15:0]   pending_value;
  logic          pending_valid;

  logic          slot_wrap;
  logic          frame_end;
  logic          in_guard;
  logic [3:0]    current_nibble;
  logic          digit_suppressed;
  logic          upper_nz3;
  logic          upper_nz2;
  logic          upper_nz1;

  assign slot_wrap = (prescaler == LAST_COUNT);
  assign frame_end = slot_wrap && (digit_idx == 2'd3);

  // The anti-ghosting guard window disappears entirely when BLANK_CYCLES is 0.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      localparam logic [PW-1:0] GUARD_LIMIT = PW'(BLANK_CYCLES);
      assign in_guard = (prescaler < GUARD_LIMIT);
    end
  endgenerate

  // Advance the slot prescaler and step the digit index on each slot wrap.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prescaler <= '0;
      digit_idx <= 2'd0;
    end else if (slot_wrap) begin
      prescaler <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Stage loads in the pending register and promote them only at a frame end;
  // a load landing on the frame-end cycle stays pending for the next frame.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      active_value  <= 16'h0000;
      pending_value <= 16'h0000;
      pending_valid <= 1'b0;
    end else begin
      if (frame_end && pending_valid) begin
        active_value  <= pending_value;
        pending_valid <= 1'b0;
      end
      if (i_Load) begin
        pending_value <= i_Value;
        pending_valid <= 1'b1;
      end
    end
  end

  // Pick the nibble that belongs to the digit currently being scanned.
  always_comb begin
    current_nibble = active_value[3:0];
    case (digit_idx)
      2'd0: current_nibble = active_value[3:0];
      2'd1: current_nibble = active_value[7:4];
      2'd2: current_nibble = active_value[11:8];
      2'd3: current_nibble = active_value[15:12];
      default: current_nibble = active_value[3:0];
    endcase
  end

  // A digit is a leading zero when it and every digit above it are zero;
  // the rightmost digit always stays lit so a zero value still shows "0".
  always_comb begin
    upper_nz3        = (active_value[15:12] != 4'h0);
    upper_nz2        = upper_nz3 || (active_value[11:8] != 4'h0);
    upper_nz1        = upper_nz2 || (active_value[7:4] != 4'h0);
    digit_suppressed = 1'b0;
    if (i_LZ_Suppress) begin
      case (digit_idx)
        2'd3: digit_suppressed = !upper_nz3;
        2'd2: digit_suppressed = !upper_nz2;
        2'd1: digit_suppressed = !upper_nz1;
        default: digit_suppressed = 1'b0;
      endcase
    end
  end

  // Register every output from this cycle's scan state so they all move together.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_DigitSelect <= 2'd0;
      o_BCD         <= 4'h0;
      o_DigitOff    <= 1'b1;
      o_Ack         <= 1'b0;
      o_FrameTick   <= 1'b0;
    end else begin
      o_DigitSelect <= digit_idx;
      o_BCD         <= current_nibble;
      o_DigitOff    <= in_guard || digit_suppressed || i_Blank;
      o_Ack         <= frame_end && pending_valid;
      o_FrameTick   <= frame_end;
    end
  end

endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
Time-multiplexed scan driver for the 4-digit FND display. It holds a 16-bit, 4-nibble BCD value and cycles a digit index 0..3 at a programmable rate. For each digit it presents the selected BCD nibble plus a 2-bit digit select and a digit-off control, which feed the digit-select decoder and the BCD-to-segment decoder. Value updates arrive through a load/ack handshake and are applied only at frame boundaries, so a frame never shows a mix of old and new digits. Blanking guard intervals suppress ghosting.

Parameters:
CLK_DIV, 100000, clock cycles per digit slot; must be >= 2
BLANK_CYCLES, 1000, cycles at the start of each slot with digits forced off; must be < CLK_DIV (0 = no guard)

Ports:
i_clk  input  1  system clock, rising-edge
i_reset_n  input  1  asynchronous active-low reset
i_Load  input  1  one-cycle strobe; capture i_Value into the pending register
i_Value  input  16  BCD digits; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3
i_LZ_Suppress  input  1  1 = blank leading zero digits
i_Blank  input  1  1 = force all digits off
o_Ack  output  1  one-cycle pulse when the pending value becomes the active value
o_DigitSelect  output  2  current digit index, drives decoder i_DigitSelect
o_DigitOff  output  1  1 = all digits off, drives decoder i_En
o_BCD  output  4  BCD nibble of current digit
o_FrameTick  output  1  one-cycle pulse at each frame boundary (digit 3 -> 0)

Behaviour:
- Reset (async assert, sync release): prescaler=0, digit index=0, active=16'h0000, pending_valid=0. Outputs: o_DigitSelect=0, o_BCD=0, o_DigitOff=1, o_Ack=0, o_FrameTick=0.
- Prescaler counts 0..CLK_DIV-1 and then wraps to 0. On the wrap cycle, digit index <= (index+1) mod 4.
- All outputs are registered. They reflect the prescaler and index state of the previous cycle, so each output changes exactly one cycle after the internal change.
- Slot timing: a slot is CLK_DIV cycles.
  - o_DigitOff=1 for the first BLANK_CYCLES cycles (prescaler < BLANK_CYCLES).
  - o_DigitOff=0 for the remaining cycles, unless the digit is suppressed or blanked.
- o_BCD = active[4*idx+3 : 4*idx]. The nibble passes through unmodified, including values > 9.
- Leading-zero suppression (i_LZ_Suppress=1):
  - Digit k (k = 3, 2, 1) is suppressed when its nibble and all higher nibbles are 0. Suppressed means o_DigitOff=1 for the whole slot.
  - Digit 0 is never suppressed.
  - o_BCD still shows the nibble.
- i_Blank=1 forces o_DigitOff=1, with 1-cycle latency. The scan keeps running underneath.
- Load handshake:
  - When i_Load=1: pending <= i_Value and pending_valid <= 1. The last load wins, so back-to-back loads overwrite pending and produce one ack.
  - Frame boundary: the wrap cycle where index==3. On that cycle, if pending_valid: active <= pending, pending_valid <= 0, and o_Ack pulses on the next cycle together with o_FrameTick.
  - Load on the boundary cycle itself: it writes pending but is NOT applied this frame. An older pending value, if present, is applied and acked. The new value stays pending (pending_valid=1) until the next boundary.
- o_FrameTick pulses every frame, 1 cycle, whether or not a load was applied.
- Reset mid-frame: immediate return to reset values. Any pending value is discarded and no ack is issued.

Test Plan:
1. Reset hold with CLK_DIV=8, BLANK_CYCLES=2 -> o_DigitOff=1, o_DigitSelect=0, o_BCD=0, o_Ack=0. After release, the first slot shows 2 off cycles then 6 on cycles, with o_BCD=0.
2. Load 16'h1234 in the first slot -> no change until the frame boundary. At the boundary o_Ack and o_FrameTick pulse together. The following frame shows o_DigitSelect 0,1,2,3 with o_BCD 4,3,2,1, each slot 2 off + 6 on cycles.
3. i_LZ_Suppress=1 with value 16'h0045 -> digits 3 and 2 off for their entire slots; digits 1 and 0 show 4 and 5. Value 16'h0000 -> only digit 0 lit, showing 0. Value 16'h0405 -> digit 3 off, digits 2, 1, 0 lit.
4. Loads of 16'h1111, then 16'h2222 within one frame -> a single o_Ack; the displayed value is 2222. A load of 16'h3333 exactly on the boundary cycle while 16'h2222 is pending -> 2222 is applied and acked now, 3333 at the next boundary with a second ack.
5. i_Blank=1 for 20 cycles -> o_DigitOff=1 throughout (1-cycle latency). o_DigitSelect keeps advancing every 8 cycles and o_FrameTick keeps pulsing.
6. Reset asserted mid-frame with a load pending -> all outputs return to reset values immediately. After release, no o_Ack occurs at the first boundary and the display shows 0000.
